vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing source that drives the colour-mapping path.
- Generates the pixel cadence, the DrawX/DrawY scan position, the blank (display-enable) flag, the active-low hsync/vsync for the DAC/connector, and frame_clk for per-frame game logic (player, AI and obstacle updates).
- Runs from the 50 MHz system clock and derives the pixel rate internally with a clock-enable divider.

Parameters:
- CLK_DIV, 2, system clocks per pixel (≥1); a pixel step occurs once every CLK_DIV Clk cycles.
- H_VISIBLE, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync width in pixels.
- H_BACK, 48, horizontal back porch in pixels; H_TOTAL = sum of the four horizontal parameters = 800.
- V_VISIBLE, 480, active lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BACK, 33, vertical back porch in lines; V_TOTAL = sum of the four vertical parameters = 525.

Ports:
- Clk  in  1  system clock; the only clock domain.
- Reset  in  1  synchronous, active-high.
- pixel_ce  out  1  one-Clk-wide strobe marking each pixel step.
- pixel_clk  out  1  square wave at the pixel rate, registered; its rising edge coincides with the Clk edge after pixel_ce.
- hs  out  1  horizontal sync, active-low.
- vs  out  1  vertical sync, active-low.
- blank  out  1  1 = visible region, 0 = blanking (colour path forces black when 0).
- frame_clk  out  1  equals vs; its rising edge (end of vsync) is the per-frame update tick.
- DrawX  out  10  current column, 0..H_TOTAL-1.
- DrawY  out  10  current line, 0..V_TOTAL-1.
- line_start  out  1  one-Clk pulse when DrawX wraps to 0.
- frame_start  out  1  one-Clk pulse when (DrawX, DrawY) wraps to (0, 0).
- frame_count  out  16  number of completed frames since reset, wraps modulo 2^16.

Behaviour:
- Divider: div_cnt counts 0..CLK_DIV-1. pixel_ce=1 in the Clk cycle where div_cnt==CLK_DIV-1. With CLK_DIV=1, pixel_ce is constantly 1.
- pixel_clk toggles when div_cnt reaches 0 and again at CLK_DIV/2 (integer division). With CLK_DIV=1 it toggles every cycle; with odd CLK_DIV its duty cycle is not 50% (accepted).
- Counters advance only on Clk edges where pixel_ce=1:
  - hc increments; at H_TOTAL-1 it wraps to 0 and vc increments.
  - vc wraps from V_TOTAL-1 to 0.
- Outputs are registered and updated together on the same edge as the counters. DrawX=hc and DrawY=vc. hs, vs and blank are always consistent with the DrawX/DrawY presented in the same cycle (zero skew).
- hs=0 iff H_VISIBLE+H_FRONT ≤ DrawX < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
- vs=0 iff V_VISIBLE+V_FRONT ≤ DrawY < V_VISIBLE+V_FRONT+V_SYNC, i.e. lines 490..491, for every pixel of those lines.
- blank=1 iff DrawX<H_VISIBLE and DrawY<V_VISIBLE.
- line_start: asserted for one Clk in the cycle that DrawX becomes 0.
- frame_start: asserted for one Clk in the cycle that DrawX and DrawY become 0. frame_count increments on that same edge.
- Reset (synchronous, any point mid-frame) sets, on the next Clk edge: div_cnt=0, pixel_clk=0, pixel_ce=0, hc=vc=0, DrawX=DrawY=0, hs=1, vs=1, blank=1, line_start=0, frame_start=0, frame_count=0. The first pixel step after Reset deasserts follows CLK_DIV cycles later.
- Reset held: all outputs remain at their reset values; no pulses are generated.
- No state beyond the counters and the output registers; no FSM beyond the counter wraps.

Decomposition:
- Package vga_pkg: the timing parameter defaults, derived constants (H_TOTAL, V_TOTAL, sync start/end positions), and the 10-bit coord_t typedef shared with the colour mapper and the sprite plotters.
- One natural sub-module, vga_pixel_div: produces pixel_ce and pixel_clk from Clk, Reset and CLK_DIV. The scan counters and sync decode stay in the top.

Test Plan:
- Reset then release with CLK_DIV=2 -> pixel_ce on every 2nd Clk. First step gives DrawX=1, DrawY=0, blank=1, hs=1, vs=1. pixel_clk period = 2 Clk.
- Run one full line -> blank falls at DrawX=640. hs is low exactly for DrawX 656..751 (96 pixels). At DrawX 799→0, line_start pulses once and DrawY increments to 1.
- Run one full frame -> blank=0 for all DrawY ≥ 480. vs is low only on lines 490 and 491 (1600 pixel steps). frame_clk rises as DrawY becomes 492. At (799, 524)→(0, 0), frame_start pulses once and frame_count becomes 1.
- Assert Reset at DrawX=300, DrawY=200 for 1 Clk -> next edge gives DrawX=0, DrawY=0, frame_count=0, hs=vs=blank=1. Counting restarts cleanly with no frame_start pulse.
- CLK_DIV=1, run 3 frames -> pixel_ce constantly 1, frame_count=3 after 3×420000 Clk, with identical sync positions each frame.
- Let frame_count run to 0xFFFF plus one frame -> it wraps to 0x0000, with no disturbance to hs, vs or blank.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: raster timing defaults, derived sync positions and the shared
// screen coordinate type.
package vga_pkg;
    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_HS_START  = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_HS_END    = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START  = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_VS_END    = DEF_VS_START + DEF_V_SYNC;

    typedef logic [9:0] coord_t;

    function automatic logic in_win(coord_t v, int lo, int hi);
        return int'(v) >= lo && int'(v) < hi;
    endfunction
endpackage

// File: rtl/vga_pixel_div.sv
// vga_pixel_div: pixel-rate clock enable and registered pixel clock
// derived from the system clock.
module vga_pixel_div #(
    parameter int CLK_DIV = 2
) (
    input  logic Clk,
    input  logic Reset,
    output logic pixel_ce,
    output logic pixel_clk
);
    localparam int DW   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int HALF = CLK_DIV / 2;
    logic [DW-1:0] div_q, div_d;
    logic ce_q, pclk_q, pclk_d;
    always_comb begin
        div_d  = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
        pclk_d = (CLK_DIV == 1) ? ~pclk_q : (int'(div_d) < HALF);
    end
    // ce is registered from the next divider value so it is low in reset
    // even when CLK_DIV is 1
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q  <= '0;
            ce_q   <= 1'b0;
            pclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            ce_q   <= (div_d == DW'(CLK_DIV - 1));
            pclk_q <= pclk_d;
        end
    end
    assign pixel_ce  = ce_q;
    assign pixel_clk = pclk_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster scan counters with registered sync, blank,
// line/frame pulses and a completed-frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        pixel_ce,
    output logic        pixel_clk,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        frame_clk,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int VS_START = V_VISIBLE + V_FRONT;

    coord_t hc_q, hc_d, vc_q, vc_d;
    logic [15:0] fc_q, fc_d;
    logic hs_q, vs_q, blank_q, ls_q, fs_q, h_wrap, v_wrap;

    vga_pixel_div #(.CLK_DIV(CLK_DIV)) u_div (
        .Clk      (Clk),
        .Reset    (Reset),
        .pixel_ce (pixel_ce),
        .pixel_clk(pixel_clk)
    );

    always_comb begin
        h_wrap = hc_q == coord_t'(H_TOTAL - 1);
        v_wrap = vc_q == coord_t'(V_TOTAL - 1);
        hc_d   = h_wrap ? '0 : hc_q + 1'b1;
        vc_d   = h_wrap ? (v_wrap ? '0 : vc_q + 1'b1) : vc_q;
        fc_d   = (h_wrap && v_wrap) ? fc_q + 16'd1 : fc_q;
    end

    // sync and blank decode the next counter values so they land with DrawX/DrawY
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hc_q    <= '0;
            vc_q    <= '0;
            fc_q    <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b1;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else if (pixel_ce) begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            fc_q    <= fc_d;
            hs_q    <= !in_win(hc_d, HS_START, HS_START + H_SYNC);
            vs_q    <= !in_win(vc_d, VS_START, VS_START + V_SYNC);
            blank_q <= in_win(hc_d, 0, H_VISIBLE) && in_win(vc_d, 0, V_VISIBLE);
            ls_q    <= h_wrap;
            fs_q    <= h_wrap && v_wrap;
        end else begin
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign frame_clk   = vs_q;
    assign blank       = blank_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks two timing generators (CLK_DIV=2 full-width lines,
// CLK_DIV=1 small raster) against an arithmetic raster model.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    localparam logic [43:0] RST_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
    localparam int A_STEPS = 800 * 13;
    localparam int B_STEPS = 35 * 13;

    logic clk = 1'b0, rst = 1'b1;
    logic ce_a, pclk_a, hs_a, vs_a, blank_a, fclk_a, ls_a, fs_a;
    logic ce_b, pclk_b, hs_b, vs_b, blank_b, fclk_b, ls_b, fs_b;
    logic [9:0] DrawX_a, DrawY_a, DrawX_b, DrawY_b;
    logic [15:0] fc_a, fc_b;
    int total = 0, bad = 0;
    int k = 0, na = 0, nb = 0;
    bit sa = 0, sb = 0;
    exp_t ea, eb;
    logic ce_exp_a, ce_exp_b, pclk_exp_a, pclk_exp_b;
    logic [43:0] obs_a, obs_b, exp_a, exp_b;

    always #5 clk = ~clk;

    vga_timing_gen #(.CLK_DIV(2), .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut_a (
        .Clk(clk), .Reset(rst), .pixel_ce(ce_a), .pixel_clk(pclk_a), .hs(hs_a), .vs(vs_a),
        .blank(blank_a), .frame_clk(fclk_a), .DrawX(DrawX_a), .DrawY(DrawY_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a));

    vga_timing_gen #(.CLK_DIV(1), .H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
                     .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut_b (
        .Clk(clk), .Reset(rst), .pixel_ce(ce_b), .pixel_clk(pclk_b), .hs(hs_b), .vs(vs_b),
        .blank(blank_b), .frame_clk(fclk_b), .DrawX(DrawX_b), .DrawY(DrawY_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b));

    // raster position as a pure function of the number of pixel steps taken
    function automatic exp_t model(int n, bit stepped, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb);
        exp_t m;
        int ht = hv + hf + hsw + hb;
        int vt = vv + vf + vsw + vb;
        int x = n % ht;
        int line = n / ht;
        int y = line % vt;
        m.x = 10'(x);
        m.y = 10'(y);
        m.hs = !(x >= hv + hf && x < hv + hf + hsw);
        m.vs = !(y >= vv + vf && y < vv + vf + vsw);
        m.blank = x < hv && y < vv;
        m.ls = stepped && x == 0;
        m.fs = stepped && x == 0 && y == 0;
        m.fc = 16'(line / vt);
        return m;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            k <= 0; na <= 0; nb <= 0; sa <= 0; sb <= 0;
        end else begin
            k <= k + 1;
            na <= na + (ce_exp_a ? 1 : 0);
            nb <= nb + (ce_exp_b ? 1 : 0);
            sa <= ce_exp_a;
            sb <= ce_exp_b;
        end
    end

    always_comb begin
        ea = model(na, sa, 640, 16, 96, 48, 6, 2, 2, 3);
        eb = model(nb, sb, 20, 4, 6, 5, 6, 2, 2, 3);
        ce_exp_a = k >= 1 && k % 2 == 1;
        pclk_exp_a = k >= 1 && k % 2 == 0;
        ce_exp_b = k >= 1;
        pclk_exp_b = k % 2 == 1;
        exp_a = {ea.x, ea.y, ea.hs, ea.vs, ea.blank, ea.ls, ea.fs, ea.fc, ce_exp_a, pclk_exp_a, ea.vs};
        exp_b = {eb.x, eb.y, eb.hs, eb.vs, eb.blank, eb.ls, eb.fs, eb.fc, ce_exp_b, pclk_exp_b, eb.vs};
    end

    assign obs_a = {DrawX_a, DrawY_a, hs_a, vs_a, blank_a, ls_a, fs_a, fc_a, ce_a, pclk_a, fclk_a};
    assign obs_b = {DrawX_b, DrawY_b, hs_b, vs_b, blank_b, ls_b, fs_b, fc_b, ce_b, pclk_b, fclk_b};

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (obs_a !== RST_VEC) begin bad++; $display("FAIL reset_a: got %h want %h", obs_a, RST_VEC); end
            total++;
            if (obs_b !== RST_VEC) begin bad++; $display("FAIL reset_b: got %h want %h", obs_b, RST_VEC); end
        end
    endtask

    task automatic test_first_step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ce_a !== 1'b1 || DrawX_a !== 10'd0) begin
            bad++; $display("FAIL first_ce_a: got ce=%b x=%0d want ce=1 x=0", ce_a, DrawX_a);
        end
        @(negedge clk);
        total++;
        if ({DrawX_a, DrawY_a, blank_a, hs_a, vs_a, pclk_a} !== {10'd1, 10'd0, 4'b1111}) begin
            bad++; $display("FAIL first_step_a: got x=%0d y=%0d b=%b hs=%b vs=%b pclk=%b want 1 0 1 1 1 1",
                            DrawX_a, DrawY_a, blank_a, hs_a, vs_a, pclk_a);
        end
        total++;
        if (DrawX_b !== 10'd1) begin bad++; $display("FAIL first_step_b: got x=%0d want 1", DrawX_b); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (pclk_a !== 1'(i % 2) || ce_a !== 1'(i % 2 == 0)) begin
                bad++; $display("FAIL pclk_period_a: got pclk=%b ce=%b want pclk=%b ce=%b",
                                pclk_a, ce_a, 1'(i % 2), 1'(i % 2 == 0));
            end
        end
    endtask

    task automatic test_line();
        int hs_low = 0, ls_cnt = 0, blank_x = -1;
        for (int i = 0; i < 4000 && na < 810; i++) begin
            @(negedge clk);
            total++;
            if (obs_a !== exp_a) begin bad++; $display("FAIL line_a: got %h want %h", obs_a, exp_a); end
            if (ce_a && !hs_a) hs_low++;
            if (ls_a) ls_cnt++;
            if (!blank_a && blank_x < 0) blank_x = int'(DrawX_a);
        end
        total++;
        if (na < 810) begin bad++; $display("FAIL line_timeout: got steps=%0d want 810", na); end
        total++;
        if (hs_low != 96) begin bad++; $display("FAIL hs_width: got %0d want 96", hs_low); end
        total++;
        if (blank_x != 640) begin bad++; $display("FAIL blank_fall_x: got %0d want 640", blank_x); end
        total++;
        if (ls_cnt != 1 || DrawY_a !== 10'd1) begin
            bad++; $display("FAIL line_wrap: got ls=%0d y=%0d want 1 1", ls_cnt, DrawY_a);
        end
    endtask

    task automatic test_frame();
        int vs_low = 0, fs_cnt = 0;
        logic prev_fclk = fclk_a;
        for (int i = 0; i < 25000 && na < A_STEPS + 5; i++) begin
            @(negedge clk);
            total++;
            if (obs_a !== exp_a) begin bad++; $display("FAIL frame_a: got %h want %h", obs_a, exp_a); end
            if (DrawY_a >= 10'd6 && blank_a !== 1'b0) begin
                total++; bad++; $display("FAIL blank_vert: got 1 at y=%0d want 0", DrawY_a);
            end
            if (ce_a && !vs_a) vs_low++;
            if (fs_a) fs_cnt++;
            if (!prev_fclk && fclk_a) begin
                total++;
                if (DrawY_a !== 10'd10 || DrawX_a !== 10'd0) begin
                    bad++; $display("FAIL frame_clk_rise: got (%0d,%0d) want (0,10)", DrawX_a, DrawY_a);
                end
            end
            prev_fclk = fclk_a;
        end
        total++;
        if (na < A_STEPS + 5) begin bad++; $display("FAIL frame_timeout: got steps=%0d want %0d", na, A_STEPS + 5); end
        total++;
        if (vs_low != 1600) begin bad++; $display("FAIL vs_width: got %0d want 1600", vs_low); end
        total++;
        if (fs_cnt != 1 || fc_a !== 16'd1) begin
            bad++; $display("FAIL frame_wrap: got fs=%0d fc=%0d want 1 1", fs_cnt, fc_a);
        end
    endtask

    task automatic test_mid_reset();
        int fs_cnt = 0;
        bit hit = 0;
        for (int i = 0; i < 25000 && !hit; i++) begin
            @(negedge clk);
            total++;
            if (obs_a !== exp_a) begin bad++; $display("FAIL pre_reset_a: got %h want %h", obs_a, exp_a); end
            hit = DrawX_a == 10'd300 && DrawY_a == 10'd2;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL mid_reset_reach: got (%0d,%0d) want (300,2)", DrawX_a, DrawY_a); end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (obs_a !== RST_VEC) begin bad++; $display("FAIL mid_reset_a: got %h want %h", obs_a, RST_VEC); end
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            total++;
            if (obs_a !== exp_a) begin bad++; $display("FAIL post_reset_a: got %h want %h", obs_a, exp_a); end
            if (fs_a) fs_cnt++;
        end
        total++;
        if (fs_cnt != 0 || fc_a !== 16'd0) begin
            bad++; $display("FAIL post_reset_frame: got fs=%0d fc=%0d want 0 0", fs_cnt, fc_a);
        end
    endtask

    task automatic test_random_reset();
        for (int it = 0; it < 4; it++) begin
            int run = int'($urandom_range(50, 600));
            int hold = int'($urandom_range(1, 3));
            for (int i = 0; i < run; i++) begin
                @(negedge clk);
                total++;
                if (obs_a !== exp_a) begin bad++; $display("FAIL rand_a: got %h want %h", obs_a, exp_a); end
                total++;
                if (obs_b !== exp_b) begin bad++; $display("FAIL rand_b: got %h want %h", obs_b, exp_b); end
            end
            rst = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                total++;
                if (obs_a !== RST_VEC || obs_b !== RST_VEC) begin
                    bad++; $display("FAIL rand_hold: got %h %h want %h", obs_a, obs_b, RST_VEC);
                end
            end
            rst = 1'b0;
        end
    endtask

    task automatic test_fast();
        int fs_cnt = 0;
        logic prev_hs = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2000 && nb < 3 * B_STEPS + 2; i++) begin
            @(negedge clk);
            total++;
            if (obs_b !== exp_b) begin bad++; $display("FAIL fast_b: got %h want %h", obs_b, exp_b); end
            total++;
            if (ce_b !== 1'b1) begin bad++; $display("FAIL fast_ce: got %b want 1", ce_b); end
            if (fs_b) fs_cnt++;
            if (prev_hs && !hs_b) begin
                total++;
                if (DrawX_b !== 10'd24) begin bad++; $display("FAIL fast_hs_pos: got %0d want 24", DrawX_b); end
            end
            prev_hs = hs_b;
        end
        total++;
        if (fs_cnt != 3 || fc_b !== 16'd3) begin
            bad++; $display("FAIL fast_frames: got fs=%0d fc=%0d want 3 3", fs_cnt, fc_b);
        end
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_line();
        test_frame();
        test_mid_reset();
        test_random_reset();
        test_fast();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
